// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: mid-bit sampling, valid strobe, framing error and break detection
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF           = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(PAYLOAD_BITS - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic                    rx_meta;
    logic                    rxs;
    logic [2:0]              state;
    logic [CW-1:0]           counter;
    logic [3:0]              bit_cnt;
    logic [1:0]              stop_cnt;
    logic [PAYLOAD_BITS-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta           <= 1'b1;
            rxs               <= 1'b1;
            state             <= IDLE;
            counter           <= '0;
            bit_cnt           <= '0;
            stop_cnt          <= '0;
            shift_reg         <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            rx_meta           <= uart_rxd;
            rxs               <= rx_meta;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;

            case (state)
                IDLE: begin
                    if (uart_rx_en && !rxs) begin
                        state   <= START;
                        counter <= '0;
                    end
                end
                START: begin
                    // A start bit that is no longer low at its centre was a glitch.
                    if (counter == HALF_LAST) begin
                        counter <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                DATA: begin
                    if (counter == CNT_LAST) begin
                        counter   <= '0;
                        shift_reg <= {rxs, shift_reg[PAYLOAD_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state    <= STOP;
                            stop_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                STOP: begin
                    if (counter == CNT_LAST) begin
                        counter <= '0;
                        if (!rxs) begin
                            state             <= WAIT_IDLE;
                            uart_rx_frame_err <= 1'b1;
                            uart_rx_break     <= (shift_reg == '0);
                        end else if (stop_cnt == STOP_LAST) begin
                            state         <= IDLE;
                            uart_rx_valid <= 1'b1;
                            uart_rx_data  <= shift_reg;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line returns high so a break cannot re-trigger.
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 10 clocks per bit
module tb_uart_rx;

    logic       clk;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    uart_rx #(
        .BIT_RATE    (5_000_000),
        .CLK_HZ      (50_000_000),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_break    (uart_rx_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_valid = 0, n_err = 0, n_brk = 0, n_both = 0;
    int valid_cyc = 0, err_cyc = 0, brk_cyc = 0;
    int t_start = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetn) begin
            if (uart_rx_valid) begin
                n_valid++;
                valid_cyc = cyc;
                rx_q.push_back(uart_rx_data);
            end
            if (uart_rx_frame_err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (uart_rx_break) begin
                n_brk++;
                brk_cyc = cyc;
            end
            if (uart_rx_valid && (uart_rx_frame_err || uart_rx_break)) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        t_start = cyc;
        uart_rxd = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (10) tick();
        end
        uart_rxd = stop_val;
        repeat (10) tick();
        uart_rxd = 1'b1;
    endtask

    function automatic logic [31:0] pop_rx();
        if (rx_q.size() == 0) return 32'hFFFF_FFFF;
        return {24'd0, rx_q.pop_front()};
    endfunction

    int v0, e0, b0, lat;

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        b0 = n_brk;
    endtask

    initial begin
        resetn     = 1'b0;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        repeat (4) tick();
        resetn = 1'b1;
        repeat (4) tick();

        check("reset_valid", uart_rx_valid, 0);
        check("reset_data", uart_rx_data, 0);
        check("reset_ferr", uart_rx_frame_err, 0);
        check("reset_break", uart_rx_break, 0);

        // 1: single frame and latency
        snap();
        send_frame(8'hA5, 1'b1);
        repeat (5) tick();
        check("a5_count", n_valid - v0, 1);
        check("a5_data", pop_rx(), 32'hA5);
        check("a5_ferr", n_err - e0, 0);
        check("a5_break", n_brk - b0, 0);
        lat = valid_cyc - t_start;
        check("a5_latency", (lat >= 96 && lat <= 99), 1);

        // 2: back-to-back frames
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (5) tick();
        check("b2b_count", n_valid - v0, 3);
        check("b2b_d0", pop_rx(), 32'h00);
        check("b2b_d1", pop_rx(), 32'hFF);
        check("b2b_d2", pop_rx(), 32'h3C);

        // 3: glitch rejected, then normal frame
        snap();
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_err - e0, 0);
        check("glitch_state", dut.state, 0);
        send_frame(8'h55, 1'b1);
        repeat (5) tick();
        check("g55_count", n_valid - v0, 1);
        check("g55_data", pop_rx(), 32'h55);

        // 4: framing error keeps old data, recovery
        snap();
        send_frame(8'h12, 1'b0);
        uart_rxd = 1'b0;
        repeat (50) tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        check("ferr_count", n_err - e0, 1);
        check("ferr_break", n_brk - b0, 0);
        check("ferr_valid", n_valid - v0, 0);
        check("ferr_hold", uart_rx_data, 32'h55);
        send_frame(8'h34, 1'b1);
        repeat (5) tick();
        check("rec_count", n_valid - v0, 1);
        check("rec_data", pop_rx(), 32'h34);

        // 5: line break
        snap();
        uart_rxd = 1'b0;
        repeat (200) tick();
        uart_rxd = 1'b1;
        repeat (20) tick();
        check("brk_ferr", n_err - e0, 1);
        check("brk_break", n_brk - b0, 1);
        check("brk_same_cycle", err_cyc == brk_cyc, 1);
        check("brk_valid", n_valid - v0, 0);

        // 6: enable gating, mid-frame disable, reset abort
        snap();
        uart_rx_en = 1'b0;
        send_frame(8'h77, 1'b1);
        repeat (10) tick();
        check("dis_valid", n_valid - v0, 0);
        check("dis_ferr", n_err - e0, 0);
        uart_rx_en = 1'b1;
        fork
            send_frame(8'h88, 1'b1);
            begin
                repeat (30) tick();
                uart_rx_en = 1'b0;
            end
        join
        repeat (5) tick();
        check("mid_dis_count", n_valid - v0, 1);
        check("mid_dis_data", pop_rx(), 32'h88);

        snap();
        uart_rx_en = 1'b1;
        uart_rxd = 1'b0;
        repeat (10) tick();
        uart_rxd = 1'b1;
        repeat (10) tick();
        uart_rxd = 1'b0;
        repeat (20) tick();
        resetn = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) tick();
        check("rst_valid", uart_rx_valid, 0);
        check("rst_data", uart_rx_data, 0);
        check("rst_ferr", uart_rx_frame_err, 0);
        check("rst_break", uart_rx_break, 0);
        resetn = 1'b1;
        repeat (120) tick();
        check("rst_no_valid", n_valid - v0, 0);
        check("rst_no_ferr", n_err - e0, 0);
        check("rst_state", dut.state, 0);

        check("strobe_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the existing uart_tx. It recovers 8N1-style frames from the asynchronous uart_rxd pin, samples each bit at its centre and presents the payload with a single-cycle valid strobe. Framing errors and line breaks are flagged. It sits between the board RX pin and the message-parsing logic of the arbitrage engine.

Parameters:
BIT_RATE, 9600, line rate in bits/s.
CLK_HZ, 50_000_000, clk frequency in Hz.
PAYLOAD_BITS, 8, data bits per frame, LSB first, range 5..8.
STOP_BITS, 1, stop bits checked per frame, range 1..2.

Ports:
clk  input  1  system clock.
resetn  input  1  reset, synchronous, active-low.
uart_rxd  input  1  asynchronous serial input, idle high.
uart_rx_en  input  1  1 = accept new start bits; 0 = ignore new frames.
uart_rx_valid  output  1  one-cycle strobe: uart_rx_data holds a new good frame.
uart_rx_data  output  PAYLOAD_BITS  last good payload, held until the next good frame.
uart_rx_frame_err  output  1  one-cycle strobe: a stop bit sampled 0.
uart_rx_break  output  1  one-cycle strobe, asserted with frame_err when the payload is all zeros.

Behaviour:
- CYCLES_PER_BIT = CLK_HZ / BIT_RATE, integer division. HALF = CYCLES_PER_BIT / 2. The cycle counter is wide enough for CYCLES_PER_BIT.
- uart_rxd passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value rxs, which lags the pin by 2 cycles.
- Reset values: uart_rx_valid=0, uart_rx_data=0, uart_rx_frame_err=0, uart_rx_break=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame: no strobe is issued and state returns to IDLE.
- State machine:
  - IDLE: if uart_rx_en=1 and rxs=0, go to START with counter=0. When uart_rx_en=0, a low line is ignored.
  - START: counter increments each cycle. At counter==HALF-1, sample rxs.
    - rxs=0: valid start bit; go to DATA with counter=0, bit_cnt=0.
    - rxs=1: glitch; return to IDLE with no strobe.
  - DATA: at counter==CYCLES_PER_BIT-1, sample rxs into the shift register (shift right, new bit enters the MSB), reset counter=0, bit_cnt++. After PAYLOAD_BITS samples, go to STOP with stop_cnt=0.
  - STOP: at counter==CYCLES_PER_BIT-1, sample rxs.
    - Any stop sample=0: raise the error flag, enter WAIT_IDLE.
    - Last stop sample=1 with no error: go to IDLE. Next cycle, uart_rx_valid=1 and uart_rx_data=shift register.
  - WAIT_IDLE: frame_err pulses 1 cycle on entry; break also pulses if the shift register is all zeros. uart_rx_data is not updated. Stay until rxs=1, then go to IDLE.
- Sampling points are mid-bit, so IDLE is re-entered half a bit before the stop bit ends. This permits back-to-back frames with no idle gap.
- uart_rx_en dropping mid-frame does not abort the frame; it only gates the IDLE→START transition.
- The valid and error strobes are mutually exclusive. Neither is ever asserted for more than 1 cycle per frame.
- There is no backpressure: consumers capture data on the strobe. A new frame overwrites uart_rx_data only on its own valid.

Test Plan:
All scenarios use CLK_HZ=50_000_000 and BIT_RATE=5_000_000, giving CYCLES_PER_BIT=10 and HALF=5.
1. Reset, then drive frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, 10 cycles each) -> exactly one uart_rx_valid pulse, uart_rx_data=0xA5, frame_err=0, break=0. The pulse lands 2+4+80+10+1 cycles after the pin start edge (±1).
2. Frames 0x00, 0xFF, 0x3C sent back-to-back with no idle gap -> three valid pulses carrying 0x00, 0xFF, 0x3C in order.
3. Pin pulsed low for 3 cycles while idle -> no strobes, state back at IDLE. A following 0x55 frame is received correctly.
4. Frame 0x12 with the stop bit driven 0 -> frame_err pulses once, valid stays 0, uart_rx_data keeps its previous value. Line held low 50 cycles, then high, then frame 0x34 -> valid pulses with 0x34.
5. Line held low for 200 cycles -> frame_err and break pulse together exactly once, with no repeats while the line stays low.
6. uart_rx_en=0 with frame 0x77 sent -> no strobes. Drop uart_rx_en mid-frame on 0x88 -> 0x88 is still received. Assert resetn=0 mid-frame -> no strobe, all outputs 0.
